// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph table,
// converter state encoding and a constant clog2 helper.
package ssd_pkg;

    // Segment patterns {a,b,c,d,e,f,g}, active-low (0 = segment lit)
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [1:0] conv_state_t;
    localparam conv_state_t ST_IDLE  = 2'd0;
    localparam conv_state_t ST_SHIFT = 2'd1;
    localparam conv_state_t ST_DONE  = 2'd2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned w = 1; w < value; w = w << 1) begin
            res++;
        end
        return res;
    endfunction

    // Nibble to glyph; codes 10-15 only have a glyph in hex display mode
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib, input logic hex_en);
        if (!hex_en && (nib > 4'd9)) begin
            return SEG_BLANK;
        end
        case (nib)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            4'hF:    return SEG_F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done
// handshake and a single-deep pending slot for starts that arrive while busy.
module ssd_bin2bcd
    import ssd_pkg::*;
#(
    parameter int unsigned BIN_W = 8,
    parameter int unsigned BCD_W = 32
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_c,
    output logic [BCD_W-1:0] bcd_o
);

    localparam int unsigned CNT_W   = clog2(BIN_W + 1);
    localparam int unsigned NIBBLES = BCD_W / 4;

    conv_state_t state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [BIN_W-1:0] pend_val_q, pend_val_d;
    logic             busy_q, busy_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Add-3 correction on every nibble >= 5, then one left shift of {bcd,bin}
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        done_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = shifted;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_DONE;
                end
                if (start_i) begin
                    pend_d     = 1'b1;
                    pend_val_d = bin_i;
                end
            end
            ST_DONE: begin
                // A start in this cycle supersedes any older pending value
                done_c = 1'b1;
                pend_d = 1'b0;
                if (start_i || pend_q) begin
                    state_d = ST_SHIFT;
                    bin_d   = start_i ? bin_i : pend_val_q;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Held one extra cycle past DONE so the display update is settled when busy drops
        busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    end

    assign busy_o = busy_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/ssd_bcd_scan_driver.sv
// N-digit seven-segment driver: BCD conversion, anode scan, leading-zero
// blanking and output polarity. Optional hex bypass under SSD_HEX_MODE_EN.
module ssd_bcd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BIN_W      = 8,
    parameter int unsigned SCAN_DIV_W = 18,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    input  logic [BIN_W-1:0]      value_in,
    input  logic                  load,
    input  logic                  blank_en,
    input  logic [NUM_DIGITS-1:0] dp_mask,
`ifdef SSD_HEX_MODE_EN
    input  logic                  hex_mode,
`endif
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            cath
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = (clog2(NUM_DIGITS) > 0) ? clog2(NUM_DIGITS) : 1;
    localparam int unsigned SCAN_W = SCAN_DIV_W + IDX_W;
    localparam logic [SCAN_W-1:0]     SCAN_LAST   = {IDX_W'(NUM_DIGITS - 1), {SCAN_DIV_W{1'b1}}};
    localparam logic [NUM_DIGITS-1:0] AN_RST_ON   = NUM_DIGITS'(1);
    localparam logic [7:0]            CATH_RST_ON = {~SEG_0, 1'b0};

    logic             conv_start;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             disp_hex;

    logic [BCD_W-1:0]      disp_q, disp_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            cath_q, cath_d;

    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  lead_zero;
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [NUM_DIGITS-1:0] an_on;
    logic [7:0]            cath_on;

`ifdef SSD_HEX_MODE_EN
    logic hex_q, hex_d;

    assign conv_start = load && !hex_mode;
    assign disp_hex   = hex_q;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            hex_q <= 1'b0;
        end else begin
            hex_q <= hex_d;
        end
    end
`else
    assign conv_start = load;
    assign disp_hex   = 1'b0;
`endif

    ssd_bin2bcd #(
        .BIN_W (BIN_W),
        .BCD_W (BCD_W)
    ) u_bin2bcd (
        .board_clk (board_clk),
        .Reset     (Reset),
        .start_i   (conv_start),
        .bin_i     (value_in),
        .busy_o    (busy),
        .done_c    (conv_done),
        .bcd_o     (conv_bcd)
    );

    // Display register: whole result lands in one edge
    always_comb begin
        disp_d = disp_q;
`ifdef SSD_HEX_MODE_EN
        hex_d = hex_q;
`endif
        if (conv_done) begin
            disp_d = conv_bcd;
`ifdef SSD_HEX_MODE_EN
            hex_d  = 1'b0;
`endif
        end
`ifdef SSD_HEX_MODE_EN
        if (load && hex_mode) begin
            disp_d = BCD_W'(value_in);
            hex_d  = 1'b1;
        end
`endif
    end

    // Free-running scan counter; explicit wrap supports non-power-of-2 digit counts
    assign scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    assign idx    = scan_q[SCAN_W-1 -: IDX_W];

    always_comb begin
        lead_zero = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero    = lead_zero && (disp_q[4*i +: 4] == 4'd0);
            blank_vec[i] = blank_en && (i != 0) && lead_zero;
        end

        sel_nib   = 4'd0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_nib   = disp_q[4*i +: 4];
                sel_dp    = dp_mask[i];
                sel_blank = blank_vec[i];
            end
        end

        an_on   = sel_blank ? '0 : (NUM_DIGITS'(1) << idx);
        cath_on = {(sel_blank ? 7'b0 : ~seg_glyph(sel_nib, disp_hex)), sel_dp};

        // Internal logic is active-high; board polarity applied only here
        an_d   = ACTIVE_LOW ? ~an_on : an_on;
        cath_d = ACTIVE_LOW ? ~cath_on : cath_on;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            disp_q <= '0;
            scan_q <= '0;
            an_q   <= ACTIVE_LOW ? ~AN_RST_ON : AN_RST_ON;
            cath_q <= ACTIVE_LOW ? ~CATH_RST_ON : CATH_RST_ON;
        end else begin
            disp_q <= disp_d;
            scan_q <= scan_d;
            an_q   <= an_d;
            cath_q <= cath_d;
        end
    end

    assign an   = an_q;
    assign cath = cath_q;

endmodule

// File: tb/tb_ssd_bcd_scan_driver.sv
// Randomized self-checking bench for ssd_bcd_scan_driver (4 digits, 8-bit
// input, 4-cycle dwell) against a timestamp-based reference model.
module tb_ssd_bcd_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned SD = 2;

    logic          board_clk = 1'b0;
    logic          Reset     = 1'b0;
    logic [BW-1:0] value_in  = '0;
    logic          load      = 1'b0;
    logic          blank_en  = 1'b1;
    logic [ND-1:0] dp_mask   = '0;
    logic          busy;
    logic [ND-1:0] an;
    logic [7:0]    cath;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: conversions tracked as completion timestamps
    int edge_n;
    bit m_active, m_pend, m_busy;
    int m_val, m_pval, m_disp, m_end, m_last_end;

    ssd_bcd_scan_driver #(
        .NUM_DIGITS (ND),
        .BIN_W      (BW),
        .SCAN_DIV_W (SD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .value_in  (value_in),
        .load      (load),
        .blank_en  (blank_en),
        .dp_mask   (dp_mask),
        .busy      (busy),
        .an        (an),
        .cath      (cath)
    );

    always #5 board_clk = ~board_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] glyph_al(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit digit_blanked(input int i);
        return blank_en && (i > 0) && (m_disp < pow10(i));
    endfunction

    task automatic model_reset();
        edge_n     = 0;
        m_active   = 1'b0;
        m_pend     = 1'b0;
        m_busy     = 1'b0;
        m_val      = 0;
        m_pval     = 0;
        m_disp     = 0;
        m_end      = 0;
        m_last_end = -100;
    endtask

    task automatic model_start(input int x);
        m_active = 1'b1;
        m_val    = x;
        m_end    = edge_n + BW + 1;
    endtask

    task automatic model_edge(input bit ld, input int v);
        if (m_active && edge_n == m_end) begin
            m_disp     = m_val;
            m_last_end = edge_n;
            if (ld) begin
                model_start(v);
                m_pend = 1'b0;
            end else if (m_pend) begin
                model_start(m_pval);
                m_pend = 1'b0;
            end else begin
                m_active = 1'b0;
            end
        end else if (m_active) begin
            if (ld) begin
                m_pend = 1'b1;
                m_pval = v;
            end
        end else if (ld) begin
            model_start(v);
        end
        m_busy = m_active || (edge_n == m_last_end);
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge
    task automatic step(input bit ld, input int v);
        load     = ld;
        value_in = BW'(v);
        @(posedge board_clk);
        edge_n++;
        model_edge(ld, v);
        @(negedge board_clk);
        load = 1'b0;
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("disp", 32'(dut.disp_q), 32'(to_bcd(m_disp)));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && busy; k++) step(1'b0, 0);
        check_eq("idle_wait", 32'(busy), 32'd0);
    endtask

    // Align to the start of digit 0's slot, then check one full scan period
    task automatic scan_check(input string tag);
        logic [ND-1:0] prev_an, exp_an;
        bit found;
        int idx, dig;
        found   = 1'b0;
        prev_an = an;
        for (int k = 0; k < 40 && !found; k++) begin
            step(1'b0, 0);
            if (!an[0] && prev_an[0]) found = 1'b1;
            prev_an = an;
        end
        check_eq({tag, "_sync"}, 32'(found), 32'd1);
        if (found) begin
            for (int k = 0; k < 16; k++) begin
                idx    = k / 4;
                dig    = (m_disp / pow10(idx)) % 10;
                exp_an = digit_blanked(idx) ? 4'b1111 : ~(4'b0001 << idx);
                check_eq({tag, "_an"}, 32'(an), 32'(exp_an));
                if (!digit_blanked(idx)) begin
                    check_eq({tag, "_cath"}, 32'(cath), 32'({glyph_al(dig), ~dp_mask[idx]}));
                end
                step(1'b0, 0);
            end
        end
    endtask

    initial begin
        int bl;
        bit ld;
        int v;

        model_reset();
        #1 Reset = 1'b1;
        #2;
        check_eq("rst_an", 32'(an), 32'(4'b1110));
        check_eq("rst_cath", 32'(cath), 32'(8'b00000011));
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge board_clk);
        @(negedge board_clk);
        Reset = 1'b0;
        scan_check("rst");

        // Single conversion: busy length and 3-digit display with blanking
        bl = 0;
        step(1'b1, 225);
        for (int k = 0; k < 30 && busy; k++) begin
            bl++;
            step(1'b0, 0);
        end
        check_eq("busy_len", 32'(bl), 32'(BW + 2));
        scan_check("v225");

        step(1'b1, 7);
        wait_idle();
        scan_check("v7_blank");
        blank_en = 1'b0;
        scan_check("v7_noblank");
        blank_en = 1'b1;

        // Loads while busy: last pending wins, busy spans both conversions
        bl = 0;
        for (int j = 0; j < 40; j++) begin
            ld = (j == 0) || (j == 3) || (j == 5);
            v  = (j == 0) ? 100 : ((j == 3) ? 37 : 42);
            step(ld, v);
            if (busy) bl++;
            else if (j > 5) break;
        end
        check_eq("busy_chain", 32'(bl), 32'(2 * BW + 3));
        scan_check("v42");

        dp_mask = 4'b0100;
        step(1'b1, 255);
        wait_idle();
        scan_check("dp255");
        dp_mask = '0;

        // Reset mid-conversion with a value pending
        step(1'b1, 200);
        for (int k = 0; k < 3; k++) step(1'b0, 0);
        step(1'b1, 50);
        step(1'b0, 0);
        Reset = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_an", 32'(an), 32'(4'b1110));
        check_eq("midrst_cath", 32'(cath), 32'(8'b00000011));
        check_eq("midrst_disp", 32'(dut.disp_q), 32'd0);
        @(negedge board_clk);
        Reset = 1'b0;
        for (int k = 0; k < 25; k++) step(1'b0, 0);
        step(1'b1, 9);
        wait_idle();
        scan_check("v9");

        // Random load traffic, including loads during SHIFT and DONE
        for (int k = 0; k < 400; k++) begin
            ld = ($urandom_range(0, 5) == 0);
            step(ld, int'($urandom_range(0, 255)));
        end
        wait_idle();

        for (int r = 0; r < 4; r++) begin
            step(1'b1, int'($urandom_range(0, 255)));
            wait_idle();
            blank_en = 1'($urandom_range(0, 1));
            dp_mask  = 4'($urandom_range(0, 15));
            scan_check("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
